// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add MUL/MLA sequencer that stalls Execute for WIDTH+1 cycles
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             StartE,
  input  logic             CondExE,
  input  logic             AccE,
  input  logic             SetFlagsE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] SrcCE,
  output logic             StallMul,
  output logic             MulDone,
  output logic [WIDTH-1:0] MulResult,
  output logic [1:0]       MulFlags,
  output logic             MulFlagWrite
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] mcand, mplier, prod, prod_next;
  logic [CW-1:0]    cnt;
  logic             s_lat, accept, last;
  // Reset outranks a same-cycle accept so no stall is raised while clearing
  assign accept    = (state == IDLE) && StartE && CondExE && !Reset;
  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign last      = cnt == CW'(WIDTH - 1);
  assign StallMul     = accept || (state == RUN);
  assign MulDone      = state == DONE;
  assign MulFlagWrite = MulDone && s_lat;
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
      s_lat     <= 1'b0;
      MulResult <= '0;
      MulFlags  <= 2'b00;
    end else if (accept) begin
      state  <= RUN;
      mcand  <= SrcAE;
      mplier <= SrcBE;
      prod   <= AccE ? SrcCE : '0;
      cnt    <= '0;
      s_lat  <= SetFlagsE;
    end else if (state == RUN) begin
      prod   <= prod_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) begin
        state     <= DONE;
        MulResult <= prod_next;
        MulFlags  <= {prod_next[WIDTH-1], prod_next == '0};
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/mul_seq.md
# mul_seq

Iterative multiply/multiply-accumulate sequencer for the pipelined CPU's Execute stage. It accepts a condition-qualified MUL/MLA in Execute and stalls the pipeline while it runs a fixed-latency shift-add loop. It then presents the WIDTH-bit result together with N/Z flags and a flag-write strobe. The hazard unit ORs StallMul into its stall/flush logic. Result and flags muxes in the Execute/Memory path select this block's outputs on MulDone.

## Interface
- WIDTH, 32, operand/result width (≥ 2)
- CLK  input  1  clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high; clears all state
- StartE  input  1  MUL/MLA instruction present in Execute
- CondExE  input  1  condition check passed for the Execute instruction
- AccE  input  1  1 = MLA (add SrcCE), 0 = MUL
- SetFlagsE  input  1  S bit of the instruction
- SrcAE  input  WIDTH  multiplicand
- SrcBE  input  WIDTH  multiplier
- SrcCE  input  WIDTH  accumulate operand (ignored when AccE=0)
- StallMul  output  1  hold Fetch/Decode/Execute this cycle
- MulDone  output  1  one-cycle pulse: MulResult/MulFlags valid
- MulResult  output  WIDTH  low WIDTH bits of SrcAE*SrcBE (+SrcCE)
- MulFlags  output  2  {N,Z} of MulResult
- MulFlagWrite  output  1  write N/Z this cycle (MulDone & latched S)

## Operation
- States: IDLE, RUN, DONE. Internal regs: multiplicand (WIDTH), multiplier (WIDTH), product (WIDTH), counter (clog2(WIDTH)+1 bits), latched S.
- IDLE: accept when StartE & CondExE. On accept, latch SrcAE, SrcBE, and S. Set product = AccE ? SrcCE : 0 and counter = 0. Go to RUN. StallMul = accept (combinational).
- IDLE with StartE & !CondExE: no accept, no stall, no MulDone, outputs unchanged.
- RUN: each cycle, if multiplier[0] then product += multiplicand (mod 2^WIDTH). Then shift multiplicand left 1 and multiplier right 1, and increment counter. After the WIDTH-th iteration (counter reaches WIDTH), go to DONE. StallMul = 1 throughout RUN.
- No early termination: RUN always lasts exactly WIDTH cycles.
- DONE: MulDone = 1, StallMul = 0, and MulFlagWrite = latched S. MulResult = product. MulFlags = {product[WIDTH-1], product==0}. Always return to IDLE next cycle.
- StartE is ignored in DONE, because the same instruction is still in Execute. A following MUL is accepted only from IDLE. Back-to-back MULs therefore incur one IDLE cycle gap minimum.
- C and V are never produced. The flag path preserves them (ARM MUL semantics).
- MulResult/MulFlags registers update only on entry to DONE. They hold their value otherwise.
- Arithmetic is unsigned modulo 2^WIDTH. This is identical to the signed low half.

## Timing
- Reset (synchronous, checked before all other logic): state = IDLE. All registers = 0. StallMul = 0, MulDone = 0, MulResult = 0, MulFlags = 2'b00, MulFlagWrite = 0.
- Accept at cycle T. RUN covers cycles T+1 .. T+WIDTH. DONE falls in cycle T+WIDTH+1. The instruction leaves Execute at the end of T+WIDTH+1.
- StallMul is high for WIDTH+1 consecutive cycles (T .. T+WIDTH). MulDone is high for exactly 1 cycle.
- Reset asserted mid-RUN: abort on that edge. No MulDone and no MulFlagWrite are issued. StallMul is 0 the cycle after.
- Reset asserted in DONE: the pulse seen in that cycle stands. State clears next edge.
- Input changes on SrcAE/SrcBE/SrcCE/AccE/SetFlagsE during RUN have no effect, because operands are latched at accept.
- CondExE is sampled only in the IDLE accept cycle.

## Test plan
- MUL 3*5, S=0, WIDTH=32: StallMul high cycles T..T+32. MulDone at T+33 with MulResult=15, MulFlags=00, MulFlagWrite=0.
- MLA 7*6+100, S=1: MulResult=142, MulFlags=00, MulFlagWrite=1 in the MulDone cycle only.
- MUL 0xFFFFFFFF*0xFFFFFFFF, S=1: MulResult=0x00000001, N=0, Z=0. Then 0x80000000*1 gives MulResult=0x80000000, N=1.
- MUL 0x00010000*0x00010000, S=1: MulResult=0, MulFlags={0,1}, MulFlagWrite=1.
- StartE=1, CondExE=0 for 5 cycles: StallMul=0, MulDone=0, outputs hold their prior values. Then CondExE=1 gives accept on that cycle.
- Accept, then assert Reset at T+10 for 1 cycle: StallMul=0 from T+11. No MulDone within 40 cycles. A new MUL 2*2 then completes normally with result 4.
